// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: states, mode codes and write-pattern table shared by the mem_sweep_seq files.
// The WAIT state exists only when MEM_SEQ_DWELL_EN is defined.
package mem_seq_pkg;
    localparam int RAM_WORDS = 64;
    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_RD_ADDR, S_RD_CHK, S_DONE
`ifdef MEM_SEQ_DWELL_EN
        , S_WAIT
`endif
    } state_e;
    typedef enum logic [1:0] {
        MODE_WR = 2'b00, MODE_VFY = 2'b01, MODE_WV = 2'b10, MODE_WV_ALT = 2'b11
    } mode_e;
    function automatic logic [31:0] exp_pat(input logic [1:0] sel);
        return sel == 2'b00 ? 32'h0000_000F : sel == 2'b01 ? 32'h0000_0DB0 :
               sel == 2'b10 ? 32'h003C_C381 : 32'hFFFF_FFFF;
    endfunction
endpackage

// File: rtl/mem_seq_addr_gen.sv
// mem_seq_addr_gen: loadable wrap-around word-address counter with a last-address flag.
module mem_seq_addr_gen
    import mem_seq_pkg::*;
#(
    parameter int AW = $clog2(RAM_WORDS)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          load_i,
    input  logic [AW-1:0] lo_i,
    input  logic [AW-1:0] hi_i,
    input  logic          reload_i,
    input  logic          inc_i,
    output logic [AW-1:0] addr_o,
    output logic          last_o
);
    logic [AW-1:0] lo_q, hi_q, addr_q, addr_d;

    always_comb addr_d = load_i ? lo_i : reload_i ? lo_q : inc_i ? addr_q + 1'b1 : addr_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lo_q   <= '0;
            hi_q   <= '0;
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
            if (load_i) begin
                lo_q <= lo_i;
                hi_q <= hi_i;
            end
        end
    end

    assign addr_o = addr_q;
    assign last_o = addr_q == hi_q;
endmodule

// File: rtl/mem_sweep_seq.sv
// mem_sweep_seq: write/verify sweep sequencer for the RAM_B display stage.
// Define MEM_SEQ_DWELL_EN to insert a DWELL_CYCLES idle WAIT after every write and check.
module mem_sweep_seq
    import mem_seq_pkg::*;
#(
    parameter int AW = $clog2(RAM_WORDS)
`ifdef MEM_SEQ_DWELL_EN
    , parameter int DWELL_CYCLES = 25000000
`endif
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [1:0]    Mode,
    input  logic [1:0]    Pat_Sel,
    input  logic [1:0]    Disp_Sel,
    input  logic [AW-1:0] Addr_Lo,
    input  logic [AW-1:0] Addr_Hi,
    input  logic [31:0]   M_R_Data,
    output logic          Mem_Write,
    output logic          Mem_Read,
    output logic [AW-1:0] Mem_Addr,
    output logic [1:0]    MUX,
    output logic          Busy,
    output logic          Done,
    output logic          Err,
    output logic [AW:0]   Err_Count,
    output logic [AW-1:0] Fail_Addr
);
    state_e        state_q, state_d, step;
    logic          start_dly_q, launch, mis, reload, inc, last;
    logic [1:0]    mode_q, pat_q;
    logic [AW:0]   err_q, err_d;
    logic [AW-1:0] fail_q, fail_d, addr;

    mem_seq_addr_gen #(.AW(AW)) u_addr (
        .clk_i(Clk), .rst_n_i(Reset), .load_i(launch), .lo_i(Addr_Lo), .hi_i(Addr_Hi),
        .reload_i(reload), .inc_i(inc), .addr_o(addr), .last_o(last)
    );

`ifdef MEM_SEQ_DWELL_EN
    state_e        ret_q, ret_d;
    logic [24:0]   cnt_q;
    logic [AW-1:0] hold_q;
`endif

    always_comb begin
        launch = Start & ~start_dly_q & (state_q == S_IDLE | state_q == S_DONE);
        mis    = state_q == S_RD_CHK && M_R_Data != exp_pat(pat_q);
        reload = state_q == S_WR & last & mode_q != MODE_WR;
        inc    = (state_q == S_WR | state_q == S_RD_CHK) & ~last;
        err_d  = launch ? '0 : mis ? err_q + 1'b1 : err_q;
        fail_d = launch ? '0 : (mis && err_q == '0) ? addr : fail_q;
        case (state_q)
            S_IDLE, S_DONE: step = launch ? (Mode == MODE_VFY ? S_RD_ADDR : S_WR) : state_q;
            S_WR:           step = !last ? S_WR : mode_q == MODE_WR ? S_DONE : S_RD_ADDR;
            S_RD_ADDR:      step = S_RD_CHK;
            S_RD_CHK:       step = last ? S_DONE : S_RD_ADDR;
            default:        step = state_q;
        endcase
        state_d = step;
`ifdef MEM_SEQ_DWELL_EN
        ret_d = ret_q;
        if (state_q == S_WR || state_q == S_RD_CHK) begin
            state_d = S_WAIT;
            ret_d   = step;
        end else if (state_q == S_WAIT) begin
            state_d = cnt_q == 25'(DWELL_CYCLES - 1) ? ret_q : S_WAIT;
        end
`endif
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= S_IDLE;
            start_dly_q <= 1'b0;
            mode_q      <= '0;
            pat_q       <= '0;
            err_q       <= '0;
            fail_q      <= '0;
        end else begin
            state_q     <= state_d;
            start_dly_q <= Start;
            err_q       <= err_d;
            fail_q      <= fail_d;
            if (launch) begin
                mode_q <= Mode;
                pat_q  <= Pat_Sel;
            end
        end
    end

`ifdef MEM_SEQ_DWELL_EN
    // The address counter already steps during WR/RD_CHK, so WAIT shows the captured one.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ret_q  <= S_IDLE;
            cnt_q  <= '0;
            hold_q <= '0;
        end else begin
            ret_q  <= ret_d;
            cnt_q  <= state_q == S_WAIT ? cnt_q + 1'b1 : '0;
            hold_q <= state_q == S_WAIT ? hold_q : addr;
        end
    end
    assign Mem_Addr = state_q == S_WAIT ? hold_q : addr;
`else
    assign Mem_Addr = addr;
`endif

    assign Mem_Write = state_q == S_WR;
    assign Mem_Read  = state_q == S_RD_ADDR | state_q == S_RD_CHK;
    assign MUX       = state_q == S_WR ? pat_q : Disp_Sel;
    assign Busy      = !(state_q == S_IDLE | state_q == S_DONE);
    assign Done      = state_q == S_DONE;
    assign Err       = state_q == S_DONE && err_q != '0;
    assign Err_Count = err_q;
    assign Fail_Addr = fail_q;
endmodule

// File: tb/tb_mem_sweep_seq.sv
// tb_mem_sweep_seq: table-driven sweeps against a 1-cycle-read RAM model, plus reset/relaunch corners.
module tb_mem_sweep_seq;
    logic        Clk = 1'b0, Reset = 1'b0, Start = 1'b0;
    logic [1:0]  Mode = '0, Pat_Sel = '0, Disp_Sel = '0;
    logic [5:0]  Addr_Lo = '0, Addr_Hi = '0;
    logic [31:0] M_R_Data;
    logic        Mem_Write, Mem_Read, Busy, Done, Err;
    logic [5:0]  Mem_Addr, Fail_Addr;
    logic [1:0]  MUX;
    logic [6:0]  Err_Count;

    mem_sweep_seq dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Mode(Mode), .Pat_Sel(Pat_Sel),
        .Disp_Sel(Disp_Sel), .Addr_Lo(Addr_Lo), .Addr_Hi(Addr_Hi), .M_R_Data(M_R_Data),
        .Mem_Write(Mem_Write), .Mem_Read(Mem_Read), .Mem_Addr(Mem_Addr), .MUX(MUX),
        .Busy(Busy), .Done(Done), .Err(Err), .Err_Count(Err_Count), .Fail_Addr(Fail_Addr)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] pat(input logic [1:0] s);
        case (s)
            2'b00:   return 32'h0000_000F;
            2'b01:   return 32'h0000_0DB0;
            2'b10:   return 32'h003C_C381;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    logic [31:0] mem [64];
    logic        load_req = 1'b0;
    logic [31:0] ld_fill, ld_av, ld_bv;
    int          ld_a, ld_b;

    always @(posedge Clk) begin
        if (load_req)
            for (int i = 0; i < 64; i++) mem[i] <= i == ld_a ? ld_av : i == ld_b ? ld_bv : ld_fill;
        else if (Mem_Write)
            mem[Mem_Addr] <= pat(MUX);
        if (Mem_Read) M_R_Data <= mem[Mem_Addr];
    end

    int         wr_cnt = 0, wr_bad = 0, both_cnt = 0;
    logic [5:0] mon_lo = '0;
    logic [1:0] mon_pat = '0;

    always @(negedge Clk) begin
        if (Mem_Write && Mem_Read) both_cnt++;
        if (Mem_Write) begin
            if (Mem_Addr !== 6'(mon_lo + wr_cnt) || MUX !== mon_pat) wr_bad++;
            wr_cnt++;
        end
    end

    int n_cmp = 0, n_bad = 0, cur = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL case%0d %s: got %0h expected %0h", cur, nm, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  mode, pat;
        logic [5:0]  lo, hi;
        logic [31:0] fill;
        int          bad_a;
        logic [31:0] bad_av;
        int          bad_b;
        logic [31:0] bad_bv;
        int          exp_busy, exp_wr;
        logic [6:0]  exp_err;
        logic [5:0]  exp_fail;
    } vec_t;

    task automatic preload(input logic [31:0] fill, input int a, input logic [31:0] av,
                           input int b, input logic [31:0] bv);
        ld_fill = fill; ld_a = a; ld_av = av; ld_b = b; ld_bv = bv;
        load_req = 1'b1;
        @(negedge Clk);
        load_req = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int busy = 0, g = 0, bad = 0;
        preload(v.fill, v.bad_a, v.bad_av, v.bad_b, v.bad_bv);
        mon_lo = v.lo; mon_pat = v.pat; wr_cnt = 0; wr_bad = 0;
        Mode = v.mode; Pat_Sel = v.pat; Addr_Lo = v.lo; Addr_Hi = v.hi; Start = 1'b1;
        @(negedge Clk);
        chk("launch_busy", Busy, 1);
        chk("launch_done_clr", Done, 0);
        Mode = ~v.mode; Pat_Sel = ~v.pat; Addr_Lo = v.lo + 6'd5; Addr_Hi = v.hi + 6'd9;
        while (!Done && g < 1000) begin
            if (Busy) busy++;
            @(negedge Clk);
            g++;
        end
        chk("done", Done, 1);
        chk("busy_cycles", busy, v.exp_busy);
        chk("err", Err, v.exp_err != 0);
        chk("err_count", Err_Count, v.exp_err);
        chk("fail_addr", Fail_Addr, v.exp_fail);
        chk("write_count", wr_cnt, v.exp_wr);
        chk("write_addr_mux", wr_bad, 0);
        if (v.exp_wr > 0) begin
            for (int i = 0; i < v.exp_wr; i++) if (mem[6'(v.lo + i)] !== pat(v.pat)) bad++;
            chk("mem_content", bad, 0);
        end
        Start = 1'b0;
        @(negedge Clk);
        chk("done_hold", Done, 1);
    endtask

    vec_t vt[6];

    initial begin
        vt[0] = '{2'b10, 2'b10, 6'd0,  6'd63, 32'h0,         -1, 32'h0, -1, 32'h0, 192, 64, 7'd0, 6'd0};
        vt[1] = '{2'b01, 2'b00, 6'd0,  6'd63, 32'h0000_000F,  5, 32'hE,  9, 32'h0, 128,  0, 7'd2, 6'd5};
        vt[2] = '{2'b00, 2'b11, 6'd62, 6'd1,  32'h0,         -1, 32'h0, -1, 32'h0,   4,  4, 7'd0, 6'd0};
        vt[3] = '{2'b10, 2'b00, 6'd7,  6'd7,  32'h0,         -1, 32'h0, -1, 32'h0,   3,  1, 7'd0, 6'd0};
        vt[4] = '{2'b11, 2'b01, 6'd10, 6'd12, 32'hDEAD_BEEF, -1, 32'h0, -1, 32'h0,   9,  3, 7'd0, 6'd0};
        vt[5] = '{2'b01, 2'b11, 6'd60, 6'd3,  32'hFFFF_FFFF, 62, 32'h1,  0, 32'h0,  16,  0, 7'd2, 6'd62};

        Disp_Sel = 2'b10;
        repeat (3) @(negedge Clk);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_err", Err, 0);
        chk("rst_wr", Mem_Write, 0);
        chk("rst_rd", Mem_Read, 0);
        chk("rst_addr", Mem_Addr, 0);
        chk("rst_errcnt", Err_Count, 0);
        chk("rst_fail", Fail_Addr, 0);
        chk("rst_mux", MUX, 2'b10);
        Reset = 1'b1;
        @(negedge Clk);

        for (int i = 0; i < 6; i++) begin
            cur = i + 1;
            run_vec(vt[i]);
        end

        // Full-range verify (5..4 wraps all 64 words), every word wrong; relaunch attempt then reset.
        cur = 7;
        preload(32'h0, -1, 32'h0, -1, 32'h0);
        Mode = 2'b01; Pat_Sel = 2'b11; Addr_Lo = 6'd5; Addr_Hi = 6'd4; Start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge Clk);
            if (k == 6) Start = 1'b0;
            if (k == 7) Start = 1'b1;
            if (k == 12) chk("seq_addr_k12", Mem_Addr, 6'd10);
        end
        chk("pre_rst_rdchk", Mem_Read, 1);
        chk("pre_rst_nowr", Mem_Write, 0);
        chk("pre_rst_addr", Mem_Addr, 6'd14);
        chk("no_relaunch_errcnt", Err_Count, 7'd9);
        chk("pre_rst_fail", Fail_Addr, 6'd5);
        Disp_Sel = 2'b01;
        #1 chk("disp_live", MUX, 2'b01);
        #1 Reset = 1'b0;
        #1;
        chk("arst_busy", Busy, 0);
        chk("arst_rd", Mem_Read, 0);
        chk("arst_addr", Mem_Addr, 0);
        chk("arst_errcnt", Err_Count, 0);
        chk("arst_fail", Fail_Addr, 0);
        chk("arst_mux", MUX, 2'b01);
        @(negedge Clk);
        Start = 1'b0;
        Reset = 1'b1;
        @(negedge Clk);
        chk("post_rst_idle", Busy, 0);
        cur = 8;
        run_vec(vt[3]);
        chk("rd_wr_overlap", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
